// File: rtl/ks_clmul_seq_pkg.sv
// -----------------------------------------------------------------------------
// ks_pkg
// Shared definitions for the sequenced Karatsuba carry-less multiplier.
//   KS_W / KS_HALF / KS_TW : operand width, half width, half-product width
//   ks_state_e             : controller state encoding
//   ks_combine()           : XOR recombination of the three Karatsuba terms
// State M3 is only reachable when KS_MUL_REG_EN is defined.
// -----------------------------------------------------------------------------
package ks_pkg;

   localparam int KS_W    = 32;
   localparam int KS_HALF = KS_W / 2;
   localparam int KS_TW   = 2 * KS_HALF - 1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      M0   = 3'd1,
      M1   = 3'd2,
      M2   = 3'd3,
      M3   = 3'd4,
      DONE = 3'd5
   } ks_state_e;

   // prod = t0 ^ ((t0^t1^t2) << HALF) ^ (t1 << W)
   // The middle term removes t0 and t1 from the cross product (lo^hi)*(lo^hi).
   // Each term is KS_TW = W-1 bits, so bit 2W-1 of the result is always 0.
   function automatic logic [2*KS_W-1:0] ks_combine(
      input logic [KS_TW-1:0] t0,
      input logic [KS_TW-1:0] t1,
      input logic [KS_TW-1:0] t2
   );
      logic [KS_TW-1:0]    mid;
      logic [2*KS_W-1:0]   r;
      mid = t0 ^ t1 ^ t2;
      r   = {{(2*KS_W-KS_TW){1'b0}}, t0}
          ^ ({{(2*KS_W-KS_TW){1'b0}}, mid} << KS_HALF)
          ^ ({{(2*KS_W-KS_TW){1'b0}}, t1}  << KS_W);
      return r;
   endfunction

endpackage

// File: rtl/ks_clmul_seq_if.sv
// -----------------------------------------------------------------------------
// ks_clmul_seq_if
// Request/response bundle for ks_clmul_seq.
//   in_valid/in_ready : operand handshake, a/b : operands (W bits)
//   flush             : synchronous abort
//   out_valid/out_ready : product handshake, prod : product (2W bits)
//   busy              : multiplier not idle
// master = requester/downstream side, slave = the multiplier.
// -----------------------------------------------------------------------------
interface ks_clmul_seq_if
   import ks_pkg::*;
#(
   parameter int W = KS_W
) ();

   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           flush;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] prod;
   logic           busy;

   modport master (
      output in_valid, a, b, flush, out_ready,
      input  in_ready, out_valid, prod, busy
   );

   modport slave (
      input  in_valid, a, b, flush, out_ready,
      output in_ready, out_valid, prod, busy
   );

endinterface

// File: rtl/ks_clmul_seq_clmul_half.sv
// -----------------------------------------------------------------------------
// clmul_half
// Combinational HALF x HALF carry-less (GF(2)[x]) multiplier.
//   a, b : HALF-bit polynomial operands
//   p    : 2*HALF-1 bit polynomial product
// -----------------------------------------------------------------------------
module clmul_half #(
   parameter int HALF = 16
) (
   input  logic [HALF-1:0]   a,
   input  logic [HALF-1:0]   b,
   output logic [2*HALF-2:0] p
);

   always_comb begin
      p = '0;
      for (int i = 0; i < HALF; i++) begin
         if (b[i]) begin
            p = p ^ ({{(HALF-1){1'b0}}, a} << i);
         end
      end
   end

endmodule

// File: rtl/ks_clmul_seq.sv
// -----------------------------------------------------------------------------
// ks_clmul_seq
// Sequenced Karatsuba carry-less multiplier. One shared clmul_half is issued
// lo*lo, hi*hi and (lo^hi)*(lo^hi) on consecutive cycles and the three terms
// are XOR-combined into a 2W-bit product.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ks_clmul_seq_if.slave (in_valid/in_ready/a/b/flush,
//           out_valid/out_ready/prod/busy)
// Build option KS_MUL_REG_EN: registers the shared multiplier output and adds
// state M3 for the final combine (accept-to-out_valid latency 5 instead of 4).
// W must equal ks_pkg::KS_W because ks_combine is sized from the package.
// -----------------------------------------------------------------------------
module ks_clmul_seq
   import ks_pkg::*;
#(
   parameter int W = KS_W
) (
   input  logic          clk,
   input  logic          rst_n,
   ks_clmul_seq_if.slave bus
);

   localparam int HALF = W / 2;
   localparam int TW   = 2 * HALF - 1;

   ks_state_e      state_q;
   ks_state_e      state_d;
   logic           run_q;
   logic           ready_c;
   logic           accept_c;

   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [TW-1:0]  t0_q;
   logic [TW-1:0]  t1_q;
   logic [2*W-1:0] prod_q;

   logic [HALF-1:0] mul_a;
   logic [HALF-1:0] mul_b;
   logic [TW-1:0]   mul_out;

`ifdef KS_MUL_REG_EN
   logic [TW-1:0]   mul_p1;
`endif

   // run_q keeps in_ready low during reset and releases it on the first edge
   // after rst_n deasserts.
   assign ready_c  = run_q & ~bus.flush &
                     ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
   assign accept_c = ready_c & bus.in_valid;

   assign bus.in_ready  = ready_c;
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.prod      = prod_q;

   // ---------------------------------------------------------------------
   // Controller
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept_c) state_d = M0;
         end
         M0:   state_d = M1;
         M1:   state_d = M2;
`ifdef KS_MUL_REG_EN
         M2:   state_d = M3;
         M3:   state_d = DONE;
`else
         M2:   state_d = DONE;
`endif
         DONE: begin
            if (bus.out_ready) begin
               state_d = accept_c ? M0 : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // flush wins over every transition, including a back-to-back accept
      if (bus.flush) state_d = IDLE;
   end

   // ---------------------------------------------------------------------
   // Shared multiplier operand select
   // ---------------------------------------------------------------------
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (state_q)
         M0: begin
            mul_a = a_q[HALF-1:0];
            mul_b = b_q[HALF-1:0];
         end
         M1: begin
            mul_a = a_q[W-1:HALF];
            mul_b = b_q[W-1:HALF];
         end
         M2: begin
            mul_a = a_q[HALF-1:0] ^ a_q[W-1:HALF];
            mul_b = b_q[HALF-1:0] ^ b_q[W-1:HALF];
         end
         default: begin
            mul_a = '0;
            mul_b = '0;
         end
      endcase
   end

   clmul_half #(
      .HALF (HALF)
   ) u_mul (
      .a (mul_a),
      .b (mul_b),
      .p (mul_out)
   );

   // ---------------------------------------------------------------------
   // Operand latch and partial-product accumulation
   // ---------------------------------------------------------------------
`ifdef KS_MUL_REG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_p1 <= '0;
      end else begin
         mul_p1 <= mul_out;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         t0_q   <= '0;
         t1_q   <= '0;
         prod_q <= '0;
      end else begin
         if (accept_c) begin
            a_q <= bus.a;
            b_q <= bus.b;
         end
`ifdef KS_MUL_REG_EN
         // each term arrives in mul_p1 one state after its operands issued
         if (state_q == M1) t0_q <= mul_p1;
         if (state_q == M2) t1_q <= mul_p1;
         if ((state_q == M3) && !bus.flush) begin
            prod_q <= ks_combine(t0_q, t1_q, mul_p1);
         end
`else
         if (state_q == M0) t0_q <= mul_out;
         if (state_q == M1) t1_q <= mul_out;
         if ((state_q == M2) && !bus.flush) begin
            prod_q <= ks_combine(t0_q, t1_q, mul_out);
         end
`endif
      end
   end

endmodule

// File: tb/tb_ks_clmul_seq.sv
// -----------------------------------------------------------------------------
// tb_ks_clmul_seq
// Directed bench for ks_clmul_seq: reset values, latency, several products,
// backpressure, back-to-back accept, flush in M1 and asynchronous reset in M2.
// Inputs change and outputs are observed on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_ks_clmul_seq;

`ifdef KS_MUL_REG_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 4;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int checks = 0;
   int errors = 0;

   ks_clmul_seq_if bus_if ();

   ks_clmul_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Present a pair for one cycle; it must be accepted on the coming edge.
   task automatic offer(input logic [31:0] av, input logic [31:0] bv, input string tag);
      bus_if.in_valid = 1'b1;
      bus_if.a        = av;
      bus_if.b        = bv;
      chk({tag, "_rdy"}, 64'(bus_if.in_ready), 64'd1);
      @(negedge clk);
      bus_if.in_valid = 1'b0;
   endtask

   // Called on the first falling edge after the accept edge; n counts cycles
   // from the accept cycle.
   task automatic expect_result(input logic [63:0] exp, input string tag);
      int n;
      n = 1;
      while (bus_if.out_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"}, 64'(n), 64'(LAT));
      chk({tag, "_prod"}, bus_if.prod, exp);
   endtask

   task automatic count_out_valid(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (bus_if.out_valid === 1'b1) cnt++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      bus_if.in_valid  = 1'b0;
      bus_if.a         = '0;
      bus_if.b         = '0;
      bus_if.flush     = 1'b0;
      bus_if.out_ready = 1'b1;

      // reset values
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready", 64'(bus_if.in_ready), 64'd0);
      chk("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
      chk("rst_busy", 64'(bus_if.busy), 64'd0);
      chk("rst_prod", bus_if.prod, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(bus_if.in_ready), 64'd1);

      // (x+1)^2 = x^2+1
      offer(32'h0000_0003, 32'h0000_0003, "t1");
      expect_result(64'h0000_0000_0000_0005, "t1");
      @(negedge clk);

      // (x^16+1)^2 = x^32+1, needs the cross term
      offer(32'h0001_0001, 32'h0001_0001, "t2");
      expect_result(64'h0000_0001_0000_0001, "t2");
      @(negedge clk);

      // backpressure: held product, no accept while out_ready low
      bus_if.out_ready = 1'b0;
      offer(32'hFFFF_FFFF, 32'h0000_0001, "t3");
      expect_result(64'h0000_0000_FFFF_FFFF, "t3");
      bus_if.in_valid = 1'b1;
      bus_if.a        = 32'h0000_0003;
      bus_if.b        = 32'h0000_0003;
      for (int i = 0; i < 6; i++) begin
         chk("t3_hold_valid", 64'(bus_if.out_valid), 64'd1);
         chk("t3_hold_prod", bus_if.prod, 64'h0000_0000_FFFF_FFFF);
         chk("t3_hold_rdy", 64'(bus_if.in_ready), 64'd0);
         @(negedge clk);
      end
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b1;
      @(negedge clk);
      chk("t3_idle_busy", 64'(bus_if.busy), 64'd0);

      // back-to-back: next pair accepted in DONE
      offer(32'h8000_0000, 32'h8000_0000, "t4a");
      expect_result(64'h4000_0000_0000_0000, "t4a");
      offer(32'h0001_0000, 32'h0001_0000, "t4b");
      expect_result(64'h0000_0001_0000_0000, "t4b");
      @(negedge clk);

      // flush in M1
      offer(32'h1234_5678, 32'h9ABC_DEF0, "t5");
      @(negedge clk);
      chk("t5_busy_m1", 64'(bus_if.busy), 64'd1);
      bus_if.flush    = 1'b1;
      bus_if.in_valid = 1'b1;
      bus_if.a        = 32'h0000_0003;
      bus_if.b        = 32'h0000_0003;
      chk("t5_flush_rdy", 64'(bus_if.in_ready), 64'd0);
      @(negedge clk);
      bus_if.flush    = 1'b0;
      bus_if.in_valid = 1'b0;
      chk("t5_busy", 64'(bus_if.busy), 64'd0);
      chk("t5_out_valid", 64'(bus_if.out_valid), 64'd0);
      chk("t5_prod_kept", bus_if.prod, 64'h0000_0001_0000_0000);
      count_out_valid(8, cnt);
      chk("t5_no_out", 64'(cnt), 64'd0);

      offer(32'h0000_0003, 32'h0000_0003, "t6");
      expect_result(64'h0000_0000_0000_0005, "t6");
      @(negedge clk);

      // all-ones squared: even powers only, top bit clear
      offer(32'hFFFF_FFFF, 32'hFFFF_FFFF, "t7");
      expect_result(64'h5555_5555_5555_5555, "t7");
      @(negedge clk);

      // asynchronous reset in M2
      offer(32'h0000_0005, 32'h0000_0003, "t8");
      @(negedge clk);
      @(negedge clk);
      chk("t8_busy_m2", 64'(bus_if.busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("t8_rst_in_ready", 64'(bus_if.in_ready), 64'd0);
      chk("t8_rst_out_valid", 64'(bus_if.out_valid), 64'd0);
      chk("t8_rst_busy", 64'(bus_if.busy), 64'd0);
      chk("t8_rst_prod", bus_if.prod, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      count_out_valid(8, cnt);
      chk("t8_no_stale", 64'(cnt), 64'd0);
      chk("t8_busy_after", 64'(bus_if.busy), 64'd0);

      // (x^2+1)(x+1) = x^3+x^2+x+1
      offer(32'h0000_0005, 32'h0000_0003, "t9");
      expect_result(64'h0000_0000_0000_000F, "t9");
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
